// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch server.
// Contents: default geometry, FSM state type, and the active-core clamp helper.
package imem_pkg;

    localparam int unsigned DEFAULT_NUM_CORES = 4;
    localparam int unsigned DEFAULT_ADDR_W    = 8;
    localparam int unsigned DEFAULT_DATA_W    = 8;
    // Width of core_sel and of core indices/pointers (covers up to 4 cores plus clamp headroom).
    localparam int unsigned IDX_W             = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_e;

    // Number of cores actually served: 0 counts as 1, anything above max_cores saturates.
    function automatic logic [IDX_W-1:0] eff_cores(input logic [IDX_W-1:0] sel,
                                                   input logic [IDX_W-1:0] max_cores);
        if (sel == '0) begin
            return IDX_W'(1);
        end else if (sel > max_cores) begin
            return max_cores;
        end else begin
            return sel;
        end
    endfunction

endpackage

// File: rtl/imem_fetch_server_rr_arbiter.sv
// Round-robin picker for the fetch server. Purely combinational.
// Ports:
//   i_eligible  - per-core eligibility mask
//   i_ptr       - search start index (must be < NUM_CORES)
//   o_grant     - index of the first eligible core at or after i_ptr, wrapping
//   o_any_grant - at least one core is eligible
module imem_fetch_server_rr_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEFAULT_NUM_CORES
) (
    input  logic [NUM_CORES-1:0] i_eligible,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [IDX_W-1:0]     o_grant,
    output logic                 o_any_grant
);

    always_comb begin
        int unsigned          idx;
        logic [NUM_CORES-1:0] w_shifted;
        o_grant     = '0;
        o_any_grant = 1'b0;
        for (int unsigned off = 0; off < NUM_CORES; off++) begin
            idx = 32'(i_ptr) + off;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            w_shifted = i_eligible >> idx;
            if (!o_any_grant && w_shifted[0]) begin
                o_any_grant = 1'b1;
                o_grant     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/imem_fetch_server.sv
// Shared instruction-memory responder for the per-core fetch initiators.
// Arbitrates round-robin among active cores, reads the shared RAM and returns the word
// with a one-cycle ins_valid pulse; also folds per-core end_op flags into all_done.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   core_sel            - active core count (0 -> 1, > NUM_CORES -> NUM_CORES)
//   req, pc             - per-core fetch request (level) and address
//   ins, ins_valid      - per-core returned instruction (held) and update pulse
//   end_op, all_done    - per-core finish flags and combined registered indication
//   wr_en/addr/data     - RAM load port, accepted only in IDLE
//   wr_err              - pulse: load rejected because a fetch was in flight
// Optional: define IMEM_STATS_EN to add fetch_cnt, per-core 16-bit saturating fetch counters.
module imem_fetch_server
    import imem_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEFAULT_NUM_CORES,
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned MEM_DEPTH = 2 ** ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IDX_W-1:0]            core_sel,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES*ADDR_W-1:0] pc,
    output logic [NUM_CORES*DATA_W-1:0] ins,
    output logic [NUM_CORES-1:0]        ins_valid,
    input  logic [NUM_CORES-1:0]        end_op,
    output logic                        all_done,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
`ifdef IMEM_STATS_EN
    output logic [NUM_CORES*16-1:0]     fetch_cnt,
`endif
    output logic                        wr_err
);

    localparam logic [IDX_W-1:0] MAX_SEL = IDX_W'(NUM_CORES);

    state_e                      r_state;
    logic [IDX_W-1:0]            r_rr;
    logic [IDX_W-1:0]            r_gnt;
    logic [ADDR_W-1:0]           r_pc;
    logic [NUM_CORES-1:0]        r_done;
    logic [NUM_CORES-1:0]        r_valid;
    logic [NUM_CORES*DATA_W-1:0] r_ins;
    logic                        r_all_done;
    logic                        r_wr_err;
    logic [DATA_W-1:0]           r_mem [MEM_DEPTH];

    logic [IDX_W-1:0]            w_eff;
    logic [NUM_CORES-1:0]        w_active;
    logic [NUM_CORES-1:0]        w_elig;
    logic [NUM_CORES-1:0]        w_done_next;
    logic [IDX_W-1:0]            w_ptr;
    logic [IDX_W-1:0]            w_arb_idx;
    logic                        w_arb_any;
    logic [ADDR_W-1:0]           w_gnt_pc;
    logic [IDX_W-1:0]            w_rr_inc;
    logic [IDX_W-1:0]            w_rr_next;
    logic [DATA_W-1:0]           w_rdata;

    assign w_eff = eff_cores(core_sel, MAX_SEL);

    always_comb begin
        w_active = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            w_active[i] = (IDX_W'(i) < w_eff);
        end
    end

    assign w_done_next = r_done | end_op;
    assign w_elig      = w_active & req & ~r_done;
    // A pointer left over from a larger core_sel restarts the search at core 0.
    assign w_ptr       = (r_rr >= w_eff) ? '0 : r_rr;
    assign w_rr_inc    = r_gnt + IDX_W'(1);
    assign w_rr_next   = (w_rr_inc >= w_eff) ? '0 : w_rr_inc;

    imem_fetch_server_rr_arbiter #(
        .NUM_CORES(NUM_CORES)
    ) u_arb (
        .i_eligible (w_elig),
        .i_ptr      (w_ptr),
        .o_grant    (w_arb_idx),
        .o_any_grant(w_arb_any)
    );

    always_comb begin
        w_gnt_pc = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (w_arb_idx == IDX_W'(i)) begin
                w_gnt_pc = pc[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Instruction RAM: contents are not reset; loads only land while idle.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // The READ-state capture into r_ins forms the synchronous read register.
    assign w_rdata = r_mem[r_pc];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr       <= '0;
            r_gnt      <= '0;
            r_pc       <= '0;
            r_done     <= '0;
            r_valid    <= '0;
            r_ins      <= '0;
            r_all_done <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_valid    <= '0;
            r_wr_err   <= 1'b0;
            r_done     <= w_done_next;
            r_all_done <= &(w_done_next | ~w_active);
            case (r_state)
                IDLE: begin
                    // A load in the same cycle wins over arbitration.
                    if (!wr_en && w_arb_any) begin
                        r_gnt   <= w_arb_idx;
                        r_pc    <= w_gnt_pc;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_wr_err <= wr_en;
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        if (r_gnt == IDX_W'(i)) begin
                            r_ins[i*DATA_W +: DATA_W] <= w_rdata;
                            r_valid[i]                <= 1'b1;
                        end
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_wr_err <= wr_en;
                    r_rr     <= w_rr_next;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ins       = r_ins;
    assign ins_valid = r_valid;
    assign all_done  = r_all_done;
    assign wr_err    = r_wr_err;

`ifdef IMEM_STATS_EN
    logic [NUM_CORES*16-1:0] r_fetch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (r_valid[i] && r_fetch_cnt[i*16 +: 16] != 16'hFFFF) begin
                    r_fetch_cnt[i*16 +: 16] <= r_fetch_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: doc/imem_fetch_server.md
Name: imem_fetch_server

Overview:
Shared instruction-memory responder serving the per-core fetch initiators inside the multi-core multiplier processor. Each core raises a fetch request with an 8-bit PC. The server arbitrates round-robin among active cores, reads an 8-bit instruction from a shared RAM, and returns it with a one-cycle valid pulse. It also collects the per-core end_op flags into a single all-done indication for the top level.

Parameters:
NUM_CORES, 4, number of fetch clients (1-4)
ADDR_W, 8, PC/address width
DATA_W, 8, instruction width
MEM_DEPTH, 256, instruction RAM words (2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
core_sel  in  3  number of active cores; 0 is treated as 1, values above NUM_CORES are treated as NUM_CORES
req  in  NUM_CORES  per-core fetch request, level
pc  in  NUM_CORES*ADDR_W  per-core fetch address, core i in bits [i*ADDR_W +: ADDR_W]
ins  out  NUM_CORES*DATA_W  per-core returned instruction, held between fetches
ins_valid  out  NUM_CORES  one-cycle pulse when the matching ins slice updates
end_op  in  NUM_CORES  per-core end-of-program flag
all_done  out  1  all active cores have finished
wr_en  in  1  instruction RAM load strobe
wr_addr  in  ADDR_W  load address
wr_data  in  DATA_W  load data
wr_err  out  1  one-cycle pulse: load rejected because the server was busy

Behaviour:
- Reset values: ins=0, ins_valid=0, all_done=0, wr_err=0, state=IDLE, rr pointer=0, done mask=0. RAM contents are not reset.
- Eligible core i: i < effective core_sel AND req[i]=1 AND done[i]=0.
- FSM states:
  - IDLE: if wr_en=1, write the RAM and stay in IDLE. wr_en has priority over fetches in the same cycle.
  - IDLE, otherwise: if any core is eligible, pick the first eligible core at or after the rr pointer (wrapping), latch its index and pc, and go to READ.
  - READ: RAM is read synchronously, 1 cycle; go to RESP.
  - RESP: drive ins[g] with the read data, pulse ins_valid[g] for 1 cycle, set rr pointer = (g+1) mod effective core_sel, and go to IDLE.
- Latency: req sampled high in IDLE at cycle N gives ins_valid at cycle N+2. Sustained throughput is one fetch per 3 cycles.
- Request protocol:
  - A core holds req until it sees its ins_valid, then may drop req or keep it high for the next fetch (new pc).
  - Dropping req after grant does not cancel the fetch; the response is still issued.
  - pc is captured at grant; later pc changes do not affect that fetch.
- wr_en in READ or RESP: the write is not performed; wr_err pulses the next cycle.
- end_op:
  - done[i] is sticky, set on end_op[i]=1. Only reset clears it.
  - A core that finishes while granted still receives its in-flight response.
  - all_done = AND of done[i] over active cores, registered (1 cycle after the last end_op).
- core_sel change: takes effect at the next IDLE arbitration. If the rr pointer is at or beyond the new count it wraps to 0. An in-flight fetch always completes.
- Reset asserted mid-fetch: immediate return to IDLE, no ins_valid pulse.

Optional Feature:
IMEM_STATS_EN:
- Defined: adds output fetch_cnt (NUM_CORES*16), per-core 16-bit saturating counters. A core's counter increments on each of its ins_valid pulses, holds at 16'hFFFF, and is cleared by reset.
- Undefined: the port and counters are absent.

Decomposition:
- Package imem_pkg: NUM_CORES, ADDR_W, DATA_W defaults; FSM state enum {IDLE, READ, RESP}; effective-core-count clamp function.
- Sub-module rr_arbiter: inputs eligible mask and pointer; outputs grant index and any_grant; combinational with no state.
- The RAM is an inferred array inside the top block.

Test Plan:
- Load the RAM via wr_en (addr 8'h00..8'h03 = 8'hA1..8'hA4); core_sel=1, req[0]=1 pc=8'h02 -> ins[7:0]=8'hA3, ins_valid[0] pulses exactly 2 cycles after req.
- core_sel=4, all req high, pc=0..3 -> grants in order 0,1,2,3,0 with ins_valid pulses 3 cycles apart; each ins slice matches its RAM word.
- core_sel=2, req=4'b1111 -> only cores 0 and 1 are served; ins_valid[3:2] stays 0.
- wr_en pulsed during READ -> wr_err=1 for one cycle, RAM word unchanged on readback.
- end_op pulses on cores 0..3 at staggered times with core_sel=4 -> all_done rises 1 cycle after the last pulse; later req from done cores is ignored.
- rst_n low during READ -> all outputs 0 immediately; no ins_valid after release until a new req.
